// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU (FETCH/DECODE/EXE/MEM/WB).
// Define MC_CTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic       rf_we,
  output logic [1:0] rf_wa_sel,
  output logic [1:0] rf_wd_sel,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       dm_we,
  output logic       dm_re,
  output logic [2:0] state,
  output logic       illegal,
  output logic       mem_timeout
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int unsigned WCW = $clog2(MEM_WAIT_MAX + 2);
  localparam logic [WCW-1:0] WAIT_TOP  = WCW'(MEM_WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = (MEM_WAIT_MAX == 0) ? '0 : WCW'(MEM_WAIT_MAX - 1);

  state_t         st;
  logic [WCW-1:0] wait_cnt;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_rtype, legal;
  logic pc_we_raw, rf_we_raw;

  always_comb begin
    is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_ori   = (opcode == OP_ORI);
    is_lui   = (opcode == OP_LUI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_rtype = is_addu || is_subu;
    legal    = is_rtype || is_jr || is_ori || is_lui || is_lw || is_sw ||
               is_beq || is_j || is_jal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          if (is_j || !legal) st <= S_FETCH;
          else if (is_jal)    st <= S_WB;
          else                st <= S_EXE;
        end
        S_EXE: begin
          if (is_beq || is_jr)    st <= S_FETCH;
          else if (is_lw || is_sw) st <= S_MEM;
          else                     st <= S_WB;
        end
        S_MEM:    if (mem_rdy) st <= is_lw ? S_WB : S_FETCH;
        S_WB:     st <= S_FETCH;
        default:  st <= S_FETCH;
      endcase
      // Counter saturates at MEM_WAIT_MAX so a stuck memory never wraps it.
      if (st == S_MEM && !mem_rdy) begin
        if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + 1'b1;
        if (MEM_WAIT_MAX != 0 && wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    pc_we_raw = 1'b0;
    npc_sel   = 2'd0;
    ir_we     = 1'b0;
    rf_we_raw = 1'b0;
    rf_wa_sel = 2'd0;
    rf_wd_sel = 2'd0;
    alu_src   = 1'b0;
    alu_op    = 3'd0;
    ext_op    = 1'b0;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    illegal   = 1'b0;

    // ALU control stays valid from EXE through WB so address/result are stable.
    if (st == S_EXE || st == S_MEM || st == S_WB) begin
      if (is_subu || is_beq) alu_op = 3'd1;
      if (is_ori) begin
        alu_src = 1'b1;
        alu_op  = 3'd2;
      end
      if (is_lui) begin
        alu_src = 1'b1;
        alu_op  = 3'd3;
      end
      if (is_lw || is_sw) begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
    end

    case (st)
      S_FETCH: ir_we = 1'b1;
      S_DECODE: begin
        if (!legal) begin
          illegal   = 1'b1;
          pc_we_raw = 1'b1;
        end else if (is_j) begin
          pc_we_raw = 1'b1;
          npc_sel   = 2'd2;
        end
      end
      S_EXE: begin
        if (is_beq) begin
          pc_we_raw = 1'b1;
          npc_sel   = zero ? 2'd1 : 2'd0;
        end else if (is_jr) begin
          pc_we_raw = 1'b1;
          npc_sel   = 2'd3;
        end
      end
      S_MEM: begin
        dm_re = is_lw;
        dm_we = is_sw;
        if (mem_rdy && is_sw) pc_we_raw = 1'b1;
      end
      S_WB: begin
        rf_we_raw = 1'b1;
        pc_we_raw = 1'b1;
        if (is_jal) begin
          npc_sel   = 2'd2;
          rf_wa_sel = 2'd2;
          rf_wd_sel = 2'd2;
        end else if (is_rtype) begin
          rf_wa_sel = 2'd1;
        end else if (is_lw) begin
          rf_wd_sel = 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed while reset is asserted mid-instruction.
  assign pc_we = pc_we_raw & ~reset;
  assign rf_we = rf_we_raw & ~reset;
  assign state = st;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected output traces built
// from the instruction rules, compared cycle by cycle with randomized instructions.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_rdy;
  logic       pc_we, ir_we, rf_we, alu_src, ext_op, dm_we, dm_re, illegal, mem_timeout;
  logic [1:0] npc_sel, rf_wa_sel, rf_wd_sel;
  logic [2:0] alu_op, state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_ctrl #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_rdy(mem_rdy), .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we),
    .rf_we(rf_we), .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .dm_we(dm_we),
    .dm_re(dm_re), .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] npc;
    logic       ir_we;
    logic       rf_we;
    logic [1:0] wa;
    logic [1:0] wd;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       dm_we;
    logic       dm_re;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  rdy;
    bit    mem_low;
  } step_t;

  step_t q[$];
  outs_t obs;
  int    checks = 0;
  int    errors = 0;
  int    low_run = 0;
  bit    exp_to = 1'b0;
  int unsigned exp_cycle = 0, exp_instr = 0;

  assign obs = '{st: state, pc_we: pc_we, npc: npc_sel, ir_we: ir_we, rf_we: rf_we,
                 wa: rf_wa_sel, wd: rf_wd_sel, alu_src: alu_src, alu_op: alu_op,
                 ext_op: ext_op, dm_we: dm_we, dm_re: dm_re, illegal: illegal};

  task automatic push(input outs_t o, input logic rdy, input bit low);
    step_t s;
    s.o = o; s.rdy = rdy; s.mem_low = low;
    q.push_back(s);
  endtask

  // Expected per-cycle trace of one instruction, from the instruction rules.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
    bit addu, subu, jr, ori, lui, lw, sw, beq, j, jal, legal;
    outs_t b, alu;
    addu = (op == 6'h00 && fn == 6'h21);
    subu = (op == 6'h00 && fn == 6'h23);
    jr   = (op == 6'h00 && fn == 6'h08);
    ori  = (op == 6'h0D); lui = (op == 6'h0F); lw  = (op == 6'h23);
    sw   = (op == 6'h2B); beq = (op == 6'h04); j   = (op == 6'h02);
    jal  = (op == 6'h03);
    legal = addu | subu | jr | ori | lui | lw | sw | beq | j | jal;
    alu = '0;
    if (subu || beq) alu.alu_op = 3'd1;
    if (ori) begin alu.alu_src = 1'b1; alu.alu_op = 3'd2; end
    if (lui) begin alu.alu_src = 1'b1; alu.alu_op = 3'd3; end
    if (lw || sw) begin alu.alu_src = 1'b1; alu.ext_op = 1'b1; end

    b = '0; b.st = 3'd0; b.ir_we = 1'b1;
    push(b, 1'($urandom), 1'b0);
    b = '0; b.st = 3'd1;
    if (!legal) begin b.illegal = 1'b1; b.pc_we = 1'b1; push(b, 1'($urandom), 1'b0); return; end
    if (j) begin b.pc_we = 1'b1; b.npc = 2'd2; push(b, 1'($urandom), 1'b0); return; end
    push(b, 1'($urandom), 1'b0);
    if (jal) begin
      b = '0; b.st = 3'd4; b.rf_we = 1'b1; b.pc_we = 1'b1;
      b.npc = 2'd2; b.wa = 2'd2; b.wd = 2'd2;
      push(b, 1'($urandom), 1'b0);
      return;
    end
    b = alu; b.st = 3'd2;
    if (beq) begin b.pc_we = 1'b1; b.npc = z ? 2'd1 : 2'd0; push(b, 1'($urandom), 1'b0); return; end
    if (jr)  begin b.pc_we = 1'b1; b.npc = 2'd3; push(b, 1'($urandom), 1'b0); return; end
    push(b, 1'($urandom), 1'b0);
    if (lw || sw) begin
      b = alu; b.st = 3'd3; b.dm_re = lw; b.dm_we = sw;
      for (int i = 0; i < waits; i++) push(b, 1'b0, 1'b1);
      if (sw) begin b.pc_we = 1'b1; push(b, 1'b1, 1'b0); return; end
      push(b, 1'b1, 1'b0);
    end
    b = alu; b.st = 3'd4; b.rf_we = 1'b1; b.pc_we = 1'b1;
    b.wa = (addu || subu) ? 2'd1 : 2'd0;
    b.wd = lw ? 2'd1 : 2'd0;
    push(b, 1'($urandom), 1'b0);
  endtask

  task automatic run_queue(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_rdy = s.rdy;
      #1;
      checks++;
      assert (obs === s.o) else begin
        errors++;
        $error("FAIL %s st%0d outs: observed=%h expected=%h", tag, s.o.st, obs, s.o);
      end
      checks++;
      assert (mem_timeout === exp_to) else begin
        errors++;
        $error("FAIL %s mem_timeout: observed=%b expected=%b", tag, mem_timeout, exp_to);
      end
`ifdef MC_CTRL_PERF_EN
      checks++;
      assert (cycle_cnt === exp_cycle && instr_cnt === exp_instr) else begin
        errors++;
        $error("FAIL %s perf: observed=%0d/%0d expected=%0d/%0d", tag, cycle_cnt, instr_cnt,
               exp_cycle, exp_instr);
      end
`endif
      @(posedge clk); #1;
      if (s.mem_low) begin
        low_run++;
        if (low_run >= 4) exp_to = 1'b1;
      end else begin
        low_run = 0;
      end
      exp_cycle++;
      if (s.o.pc_we) exp_instr++;
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int waits, input string tag);
    opcode = op; funct = fn; zero = z;
    plan(op, fn, z, waits);
    run_queue(tag);
  endtask

  task automatic reset_model();
    exp_to = 1'b0; low_run = 0; exp_cycle = 0; exp_instr = 0;
  endtask

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
    @(posedge clk); #1;
    checks++;
    assert (state === 3'd0 && ir_we === 1'b1 && pc_we === 1'b0 && mem_timeout === 1'b0) else begin
      errors++;
      $error("FAIL reset_hold: observed st=%0d ir=%b pc=%b to=%b expected st=0 ir=1 pc=0 to=0",
             state, ir_we, pc_we, mem_timeout);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    reset_model();

    // Directed sequence; the jal + illegal pair sits right after reset for the perf counts.
    do_instr(6'h03, 6'h00, 1'b0, 0, "jal");
    do_instr(6'h3F, 6'h00, 1'b0, 0, "illegal_3f");
`ifdef MC_CTRL_PERF_EN
    #1;
    checks++;
    assert (instr_cnt === 32'd2 && cycle_cnt === 32'd5) else begin
      errors++;
      $error("FAIL perf_jal_illegal: observed=%0d/%0d expected=2/5", instr_cnt, cycle_cnt);
    end
`endif
    do_instr(6'h00, 6'h21, 1'b0, 0, "addu");
    do_instr(6'h04, 6'h00, 1'b1, 0, "beq_taken");
    do_instr(6'h04, 6'h00, 1'b0, 0, "beq_not_taken");
    do_instr(6'h23, 6'h00, 1'b0, 3, "lw_wait3");
    do_instr(6'h02, 6'h00, 1'b0, 0, "j");
    do_instr(6'h00, 6'h08, 1'b0, 0, "jr");
    do_instr(6'h00, 6'h2A, 1'b0, 0, "rtype_bad_funct");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 11))
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h23; end
        2: begin op = 6'h00; fn = 6'h08; end
        3: begin op = 6'h0D; fn = 6'($urandom); end
        4: begin op = 6'h0F; fn = 6'($urandom); end
        5: begin op = 6'h23; fn = 6'($urandom); end
        6: begin op = 6'h2B; fn = 6'($urandom); end
        7: begin op = 6'h04; fn = 6'($urandom); end
        8: begin op = 6'h02; fn = 6'($urandom); end
        9: begin op = 6'h03; fn = 6'($urandom); end
        10: begin op = 6'h00; fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      do_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end

    // sw against a memory that never answers: timeout after 4 waits, then reset.
    opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
    plan(6'h2B, 6'h00, 1'b0, 7);
    void'(q.pop_back());
    run_queue("sw_timeout");
    reset = 1'b1; mem_rdy = 1'b1;
    #1;
    checks++;
    assert (pc_we === 1'b0 && rf_we === 1'b0 && dm_we === 1'b1 && mem_timeout === 1'b1) else begin
      errors++;
      $error("FAIL reset_in_mem: observed pc=%b rf=%b dmw=%b to=%b expected pc=0 rf=0 dmw=1 to=1",
             pc_we, rf_we, dm_we, mem_timeout);
    end
    @(posedge clk); #1;
    checks++;
    assert (state === 3'd0 && dm_we === 1'b0 && dm_re === 1'b0 && mem_timeout === 1'b0 &&
            pc_we === 1'b0) else begin
      errors++;
      $error("FAIL reset_after_mem: observed st=%0d dmw=%b dmr=%b to=%b pc=%b expected 0/0/0/0/0",
             state, dm_we, dm_re, mem_timeout, pc_we);
    end
    reset = 1'b0;
    reset_model();
    do_instr(6'h0D, 6'h00, 1'b0, 0, "ori_after_reset");
    do_instr(6'h0F, 6'h00, 1'b0, 0, "lui");
    do_instr(6'h2B, 6'h00, 1'b0, 2, "sw_wait2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
